// File: rtl/axi_adder_master_pkg.sv
// Shared definitions for the AXI adder master: adder register offsets,
// AXI response codes and the sequencing FSM state encoding.
package axi_adder_master_pkg;

  // Register offsets inside the adder peripheral, relative to its base address.
  localparam int unsigned RegAOff   = 32'h0;
  localparam int unsigned RegBOff   = 32'h4;
  localparam int unsigned RegSumOff = 32'h8;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrA   = 3'd1,
    StWrB   = 3'd2,
    StRdSum = 3'd3,
    StResp  = 3'd4
  } state_e;

  // EXOKAY is not expected from a plain AXI4-Lite slave, so it counts as an error.
  function automatic logic resp_is_okay(input logic [1:0] resp);
    return resp == RespOkay;
  endfunction

endpackage

// File: rtl/axi_adder_master_wr_xact.sv
// Single AXI4-Lite write transaction engine (AW + W + B).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             launch a write; addr_i/data_i are captured on this cycle
//   done_o, resp_o      one-cycle pulse on B handshake, with BRESP
//   aw*/w*/b*           AXI4-Lite write channels
// start_i may be raised in the same cycle as done_o so transfers run back to back.
module axi_adder_master_wr_xact #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 done_o,
  output logic [1:0]           resp_o,
  output logic [AddrWidth-1:0] awaddr_o,
  output logic                 awvalid_o,
  input  logic                 awready_i,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  input  logic [1:0]           bresp_i,
  input  logic                 bvalid_i,
  output logic                 bready_o
);

  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 busy_q, busy_d;
  logic [AddrWidth-1:0] awaddr_q, awaddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  assign done_o    = bready_q & bvalid_i;
  assign resp_o    = bresp_i;
  assign awaddr_o  = awaddr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    busy_d    = busy_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;

    // AW and W retire independently, in either order.
    if (awvalid_q && awready_i) awvalid_d = 1'b0;
    if (wvalid_q && wready_i)   wvalid_d  = 1'b0;

    if (done_o) begin
      bready_d = 1'b0;
      busy_d   = 1'b0;
    end else if (busy_q) begin
      // BREADY only once both address and data have been accepted.
      bready_d = ~awvalid_d & ~wvalid_d;
    end

    if (start_i) begin
      busy_d    = 1'b1;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      bready_d  = 1'b0;
      awaddr_d  = addr_i;
      wdata_d   = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: rtl/axi_adder_master.sv
// AXI4-Lite master for the adder peripheral. A command (cmd_a, cmd_b) is written
// to registers A and B, the SUM register is read back, and the result is returned
// on the response port together with the first non-OKAY response code, if any.
// Ports:
//   m00_axi_aclk, m00_axi_areset   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_a/b   command handshake and operands
//   rsp_valid/rsp_ready            response handshake
//   rsp_sum, rsp_err, rsp_code     read-back sum (0 on error), error flag, first bad resp
//   m00_axi_*                      AXI4-Lite master port to the adder's S_AXI
module axi_adder_master
  import axi_adder_master_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_BASE_ADDR        = 0
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_sum,
  output logic                            rsp_err,
  output logic [1:0]                      rsp_code,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                      m00_axi_awprot,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrA   =
    C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + RegAOff);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrB   =
    C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + RegBOff);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrSum =
    C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + RegSumOff);

  state_e                          state_q, state_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   b_q, b_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                            err_q, err_d;
  logic [1:0]                      code_q, code_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;

  logic                            wr_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data;
  logic                            wr_done;
  logic [1:0]                      wr_resp;

  axi_adder_master_wr_xact #(
    .AddrWidth (C_M_AXI_ADDR_WIDTH),
    .DataWidth (C_M_AXI_DATA_WIDTH)
  ) u_wr_xact (
    .clk_i     (m00_axi_aclk),
    .rst_i     (m00_axi_areset),
    .start_i   (wr_start),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .done_o    (wr_done),
    .resp_o    (wr_resp),
    .awaddr_o  (m00_axi_awaddr),
    .awvalid_o (m00_axi_awvalid),
    .awready_i (m00_axi_awready),
    .wdata_o   (m00_axi_wdata),
    .wvalid_o  (m00_axi_wvalid),
    .wready_i  (m00_axi_wready),
    .bresp_i   (m00_axi_bresp),
    .bvalid_i  (m00_axi_bvalid),
    .bready_o  (m00_axi_bready)
  );

  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_araddr  = araddr_q;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_sum   = sum_q;
  assign rsp_err   = err_q;
  assign rsp_code  = code_q;

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    sum_d     = sum_q;
    err_d     = err_q;
    code_d    = code_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    wr_start  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          // Launch the A write on the accept edge so AWVALID/WVALID rise on entry.
          wr_start = 1'b1;
          wr_addr  = AddrA;
          wr_data  = cmd_a;
          b_d      = cmd_b;
          sum_d    = '0;
          err_d    = 1'b0;
          code_d   = RespOkay;
          state_d  = StWrA;
        end
      end
      StWrA: begin
        if (wr_done) begin
          if (resp_is_okay(wr_resp)) begin
            wr_start = 1'b1;
            wr_addr  = AddrB;
            wr_data  = b_q;
            state_d  = StWrB;
          end else begin
            err_d   = 1'b1;
            code_d  = wr_resp;
            state_d = StResp;
          end
        end
      end
      StWrB: begin
        if (wr_done) begin
          if (resp_is_okay(wr_resp)) begin
            arvalid_d = 1'b1;
            araddr_d  = AddrSum;
            state_d   = StRdSum;
          end else begin
            err_d   = 1'b1;
            code_d  = wr_resp;
            state_d = StResp;
          end
        end
      end
      StRdSum: begin
        if (arvalid_q && m00_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && m00_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = StResp;
          if (resp_is_okay(m00_axi_rresp)) begin
            sum_d = m00_axi_rdata;
          end else begin
            sum_d  = '0;
            err_d  = 1'b1;
            code_d = m00_axi_rresp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q   <= StIdle;
      b_q       <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      code_q    <= code_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
    end
  end

endmodule
